// File: rtl/eth_rxpause_pkg.sv
// eth_rxpause_pkg: shared types and constants for the receive-side PAUSE
// frame controller. The receive FSM states, the reserved PAUSE multicast
// destination and the byte offsets of the MAC control header live here.
package eth_rxpause_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECV    = 2'd1,
        ST_DISCARD = 2'd2
    } rx_state_e;

    // Reserved MAC control multicast address 01-80-C2-00-00-01
    localparam logic [47:0] PAUSE_MCAST_ADDR = 48'h0180_C200_0001;

    // Header byte offsets, counted from destination byte 0
    localparam logic [5:0] OFS_SRC       = 6'd6;
    localparam logic [5:0] OFS_TYPE      = 6'd12;
    localparam logic [5:0] OFS_OPCODE    = 6'd14;
    localparam logic [5:0] OFS_TIMER     = 6'd16;
    localparam logic [5:0] MIN_PAUSE_LEN = 6'd18;
    localparam logic [5:0] CNT_MAX       = 6'd63;

    // Byte idx (0 = first on the wire) of a 48-bit address
    function automatic logic [7:0] addr_byte(input logic [47:0] addr,
                                             input logic [2:0]  idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = addr[47:40];
            3'd1:    b = addr[39:32];
            3'd2:    b = addr[31:24];
            3'd3:    b = addr[23:16];
            3'd4:    b = addr[15:8];
            3'd5:    b = addr[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/eth_pausetimer.sv
// eth_pausetimer: holds the remaining pause quanta and the registered Pause
// request. A load from an accepted PAUSE frame beats a coincident slot tick;
// dropping rx_flow clears the timer outright.
module eth_pausetimer (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_flow,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        slot_tick,
    output logic [15:0] pause_timer,
    output logic        pause
);

    logic [15:0] timer_q, timer_d;
    logic        pause_q, pause_d;

    // Next timer value: clear, load, or saturating decrement on a slot tick
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
        timer_d = timer_q;
        if (!rx_flow) begin
            timer_d = '0;
        end else if (load) begin
            timer_d = load_val;
        end else if (slot_tick && (timer_q != '0)) begin
            timer_d = timer_q - 16'd1;
        end
        pause_d = (timer_q != '0) && rx_flow;
    end

    // Timer and Pause registers with synchronous reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            timer_q <= '0;
            pause_q <= 1'b0;
        end else begin
            timer_q <= timer_d;
            pause_q <= pause_d;
        end
    end

    assign pause_timer = timer_q;
    assign pause       = pause_q;

endmodule

// File: rtl/eth_rxpausectrl.sv
// eth_rxpausectrl: parses received frames for MAC control PAUSE requests,
// loads the pause timer on an accepted PAUSE and flags control frames that
// must not reach the host.
// Build option: define ETH_RXPAUSE_UNICAST_EN to also accept PAUSE frames
// addressed to the station address MAC.
module eth_rxpausectrl
    import eth_rxpause_pkg::*;
#(
    parameter logic [15:0] CTRL_TYPE    = 16'h8808,
    parameter logic [15:0] PAUSE_OPCODE = 16'h0001
) (
    input  logic        MRxClk,
    input  logic        RxReset,
    input  logic [7:0]  RxData,
    input  logic        RxValid,
    input  logic        RxStartFrm,
    input  logic        RxEndFrm,
    input  logic        CrcOk,
    input  logic        RxFlow,
    input  logic        PassAll,
    input  logic [47:0] MAC,
    input  logic        SlotTick,
    output logic        Pause,
    output logic        ReceivedPauseFrm,
    output logic        DropFrame,
    output logic [15:0] PauseTimer
);

`ifdef ETH_RXPAUSE_UNICAST_EN
    localparam bit UNICAST_EN = 1'b1;
`else
    localparam bit UNICAST_EN = 1'b0;
`endif

    rx_state_e   state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        mc_hit_q, mc_hit_d;
    logic        uc_hit_q, uc_hit_d;
    logic        type_hi_q, type_hi_d;
    logic        ctrl_type_q, ctrl_type_d;
    logic        op_hi_q, op_hi_d;
    logic        pause_op_q, pause_op_d;
    logic [15:0] timer_val_q, timer_val_d;
    logic        rx_pause_q, rx_pause_d;
    logic        drop_q, drop_d;

    logic        start;
    logic        discard;
    logic        accept;

    assign start   = RxValid && RxStartFrm;
    // Leave RECV once neither address can still match, or once the type field is known not to be MAC control
    assign discard = !(mc_hit_q || uc_hit_q) ||
                     ((cnt_q >= OFS_OPCODE) && !ctrl_type_q);

    // State and header-tracking registers
    always_ff @(posedge MRxClk) begin
        if (RxReset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            mc_hit_q    <= 1'b0;
            uc_hit_q    <= 1'b0;
            type_hi_q   <= 1'b0;
            ctrl_type_q <= 1'b0;
            op_hi_q     <= 1'b0;
            pause_op_q  <= 1'b0;
            timer_val_q <= '0;
            rx_pause_q  <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mc_hit_q    <= mc_hit_d;
            uc_hit_q    <= uc_hit_d;
            type_hi_q   <= type_hi_d;
            ctrl_type_q <= ctrl_type_d;
            op_hi_q     <= op_hi_d;
            pause_op_q  <= pause_op_d;
            timer_val_q <= timer_val_d;
            rx_pause_q  <= rx_pause_d;
            drop_q      <= drop_d;
        end
    end

    // Next-state: a frame start restarts reception from any state
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = ST_RECV;
        end else begin
            case (state_q)
                ST_RECV: begin
                    if (RxEndFrm)     state_d = ST_IDLE;
                    else if (discard) state_d = ST_DISCARD;
                end
                ST_DISCARD: begin
                    if (RxEndFrm) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Header parsing: byte counter, address match, type/opcode flags, timer field
    always_comb begin
        cnt_d       = cnt_q;
        mc_hit_d    = mc_hit_q;
        uc_hit_d    = uc_hit_q;
        type_hi_d   = type_hi_q;
        ctrl_type_d = ctrl_type_q;
        op_hi_d     = op_hi_q;
        pause_op_d  = pause_op_q;
        timer_val_d = timer_val_q;
        if (start) begin
            cnt_d       = 6'd1;
            mc_hit_d    = (RxData == PAUSE_MCAST_ADDR[47:40]);
            uc_hit_d    = UNICAST_EN && (RxData == MAC[47:40]);
            type_hi_d   = 1'b0;
            ctrl_type_d = 1'b0;
            op_hi_d     = 1'b0;
            pause_op_d  = 1'b0;
            timer_val_d = '0;
        end else if ((state_q == ST_RECV) && RxValid) begin
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + 6'd1;
            if (cnt_q < OFS_SRC) begin
                mc_hit_d = mc_hit_q &&
                           (RxData == addr_byte(PAUSE_MCAST_ADDR, cnt_q[2:0]));
                uc_hit_d = uc_hit_q && UNICAST_EN &&
                           (RxData == addr_byte(MAC, cnt_q[2:0]));
            end
            case (cnt_q)
                OFS_TYPE:          type_hi_d   = (RxData == CTRL_TYPE[15:8]);
                OFS_TYPE + 6'd1:   ctrl_type_d = type_hi_q && (RxData == CTRL_TYPE[7:0]);
                OFS_OPCODE:        op_hi_d     = (RxData == PAUSE_OPCODE[15:8]);
                OFS_OPCODE + 6'd1: pause_op_d  = op_hi_q && (RxData == PAUSE_OPCODE[7:0]);
                OFS_TIMER:         timer_val_d[15:8] = RxData;
                OFS_TIMER + 6'd1:  timer_val_d[7:0]  = RxData;
                default: ;
            endcase
        end
    end

    // End-of-frame decisions: accept the PAUSE and/or hide the control frame
    always_comb begin
        accept = (state_q == ST_RECV) && RxEndFrm && !start &&
                 (mc_hit_q || uc_hit_q) && ctrl_type_q && pause_op_q &&
                 CrcOk && (cnt_q >= MIN_PAUSE_LEN) && RxFlow;
        rx_pause_d = accept;
        drop_d     = (state_q == ST_RECV) && RxEndFrm && !start &&
                     ctrl_type_q && !PassAll;
    end

    eth_pausetimer u_pausetimer (
        .clk         (MRxClk),
        .rst         (RxReset),
        .rx_flow     (RxFlow),
        .load        (accept),
        .load_val    (timer_val_q),
        .slot_tick   (SlotTick),
        .pause_timer (PauseTimer),
        .pause       (Pause)
    );

    assign ReceivedPauseFrm = rx_pause_q;
    assign DropFrame        = drop_q;

endmodule

// File: tb/tb_eth_rxpausectrl.sv
// tb_eth_rxpausectrl: directed PAUSE-frame scenarios with hand-computed
// expectations for eth_rxpausectrl.
module tb_eth_rxpausectrl;
    import eth_rxpause_pkg::*;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_start;
    logic        rx_end;
    logic        crc_ok;
    logic        rx_flow;
    logic        pass_all;
    logic [47:0] mac;
    logic        slot_tick;
    logic        pause;
    logic        rx_pause_frm;
    logic        drop_frame;
    logic [15:0] pause_timer;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [47:0] MCAST = 48'h0180_C200_0001;
    localparam logic [47:0] STA   = 48'h0011_2233_4455;

`ifdef ETH_RXPAUSE_UNICAST_EN
    localparam bit UC_EXP = 1'b1;
`else
    localparam bit UC_EXP = 1'b0;
`endif

    eth_rxpausectrl dut (
        .MRxClk           (clk),
        .RxReset          (rst),
        .RxData           (rx_data),
        .RxValid          (rx_valid),
        .RxStartFrm       (rx_start),
        .RxEndFrm         (rx_end),
        .CrcOk            (crc_ok),
        .RxFlow           (rx_flow),
        .PassAll          (pass_all),
        .MAC              (mac),
        .SlotTick         (slot_tick),
        .Pause            (pause),
        .ReceivedPauseFrm (rx_pause_frm),
        .DropFrame        (drop_frame),
        .PauseTimer       (pause_timer)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic sof);
        rx_data  = d;
        rx_valid = 1'b1;
        rx_start = sof;
        step();
        rx_valid = 1'b0;
        rx_start = 1'b0;
        rx_data  = 8'h00;
    endtask

    // Send bytes lo..hi of an 18-byte control frame header
    task automatic send_frame(input logic [47:0] dst, input logic [15:0] typ,
                              input logic [15:0] op, input logic [15:0] tmr,
                              input int lo, input int hi);
        logic [7:0] b [18];
        for (int i = 0; i < 6; i++) b[i] = dst[8*(5-i) +: 8];
        b[6]  = 8'h02; b[7]  = 8'h00; b[8]  = 8'h00;
        b[9]  = 8'h00; b[10] = 8'h00; b[11] = 8'h01;
        b[12] = typ[15:8]; b[13] = typ[7:0];
        b[14] = op[15:8];  b[15] = op[7:0];
        b[16] = tmr[15:8]; b[17] = tmr[7:0];
        for (int i = lo; i <= hi; i++) send_byte(b[i], i == 0);
    endtask

    task automatic end_frame(input logic crc, input logic tick);
        rx_end    = 1'b1;
        crc_ok    = crc;
        slot_tick = tick;
        step();
        rx_end    = 1'b0;
        crc_ok    = 1'b0;
        slot_tick = 1'b0;
    endtask

    task automatic tick();
        slot_tick = 1'b1;
        step();
        slot_tick = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; rx_start = 1'b0;
        rx_end = 1'b0; crc_ok = 1'b0; rx_flow = 1'b1; pass_all = 1'b0;
        mac = 48'h0; slot_tick = 1'b0;
        step(); step();
        check("rst_pause", pause, 1'b0);
        check("rst_rpf", rx_pause_frm, 1'b0);
        check("rst_drop", drop_frame, 1'b0);
        check("rst_timer", pause_timer, 16'd0);
        check("rst_state", dut.state_q, ST_IDLE);
        rst = 1'b0;
        step();

        // Basic PAUSE to multicast, timer 3
        send_frame(MCAST, 16'h8808, 16'h0001, 16'h0003, 0, 17);
        end_frame(1'b1, 1'b0);
        check("p3_rpf", rx_pause_frm, 1'b1);
        check("p3_timer", pause_timer, 16'd3);
        check("p3_drop", drop_frame, 1'b1);
        check("p3_pause_lag", pause, 1'b0);
        step();
        check("p3_rpf_one", rx_pause_frm, 1'b0);
        check("p3_pause", pause, 1'b1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("p3_tick_timer", pause_timer, 16'(3 - i));
            check("p3_tick_pause", pause, 1'b1);
        end
        step();
        check("p3_pause_end", pause, 1'b0);
        tick();
        check("p3_no_underflow", pause_timer, 16'd0);

        // Bad CRC: no pulse, drop still flagged; with PassAll no drop
        send_frame(MCAST, 16'h8808, 16'h0001, 16'h0003, 0, 17);
        end_frame(1'b0, 1'b0);
        check("crc_rpf", rx_pause_frm, 1'b0);
        check("crc_drop", drop_frame, 1'b1);
        check("crc_timer", pause_timer, 16'd0);
        step();
        check("crc_pause", pause, 1'b0);
        pass_all = 1'b1;
        send_frame(MCAST, 16'h8808, 16'h0001, 16'h0003, 0, 17);
        end_frame(1'b0, 1'b0);
        check("passall_drop", drop_frame, 1'b0);
        pass_all = 1'b0;

        // Non-control type goes to DISCARD
        send_frame(MCAST, 16'h0800, 16'h0001, 16'h0003, 0, 17);
        check("ip_state", dut.state_q, ST_DISCARD);
        end_frame(1'b1, 1'b0);
        check("ip_rpf", rx_pause_frm, 1'b0);
        check("ip_drop", drop_frame, 1'b0);
        check("ip_state_end", dut.state_q, ST_IDLE);

        // Timer 5 then a zero PAUSE
        send_frame(MCAST, 16'h8808, 16'h0001, 16'h0005, 0, 17);
        end_frame(1'b1, 1'b0);
        check("z_timer5", pause_timer, 16'd5);
        step();
        check("z_pause_on", pause, 1'b1);
        send_frame(MCAST, 16'h8808, 16'h0001, 16'h0000, 0, 17);
        end_frame(1'b1, 1'b0);
        check("z_rpf", rx_pause_frm, 1'b1);
        check("z_timer0", pause_timer, 16'd0);
        check("z_pause_still", pause, 1'b1);
        step();
        check("z_pause_off", pause, 1'b0);

        // Load coinciding with a slot tick
        send_frame(MCAST, 16'h8808, 16'h0001, 16'h0002, 0, 17);
        end_frame(1'b1, 1'b1);
        check("lt_timer2", pause_timer, 16'd2);
        tick();
        check("lt_timer1", pause_timer, 16'd1);
        tick();
        check("lt_timer0", pause_timer, 16'd0);

        // RxFlow low: frame not honoured
        rx_flow = 1'b0;
        send_frame(MCAST, 16'h8808, 16'h0001, 16'h0009, 0, 17);
        end_frame(1'b1, 1'b0);
        check("noflow_rpf", rx_pause_frm, 1'b0);
        check("noflow_timer", pause_timer, 16'd0);
        rx_flow = 1'b1;

        // 17-byte frame: too short to accept, still a control frame
        send_frame(MCAST, 16'h8808, 16'h0001, 16'h0009, 0, 16);
        end_frame(1'b1, 1'b0);
        check("short_rpf", rx_pause_frm, 1'b0);
        check("short_drop", drop_frame, 1'b1);

        // Wrong opcode
        send_frame(MCAST, 16'h8808, 16'h0002, 16'h0009, 0, 17);
        end_frame(1'b1, 1'b0);
        check("op_rpf", rx_pause_frm, 1'b0);
        check("op_drop", drop_frame, 1'b1);
        check("op_timer", pause_timer, 16'd0);

        // End-of-frame while idle is ignored
        end_frame(1'b1, 1'b0);
        check("idle_end_rpf", rx_pause_frm, 1'b0);
        check("idle_end_drop", drop_frame, 1'b0);

        // Restart mid-frame abandons the partial PAUSE
        send_frame(MCAST, 16'h8808, 16'h0001, 16'h0009, 0, 16);
        send_frame(48'h0A0B_0C0D_0E0F, 16'h8808, 16'h0001, 16'h0009, 0, 17);
        end_frame(1'b1, 1'b0);
        check("restart_rpf", rx_pause_frm, 1'b0);
        check("restart_drop", drop_frame, 1'b0);
        check("restart_timer", pause_timer, 16'd0);

        // Reset mid-frame: remaining bytes ignored
        send_frame(MCAST, 16'h8808, 16'h0001, 16'h0009, 0, 9);
        rst = 1'b1; step(); rst = 1'b0;
        send_frame(MCAST, 16'h8808, 16'h0001, 16'h0009, 10, 17);
        end_frame(1'b1, 1'b0);
        check("rstmid_rpf", rx_pause_frm, 1'b0);
        check("rstmid_drop", drop_frame, 1'b0);
        check("rstmid_timer", pause_timer, 16'd0);

        // Reset during pause
        send_frame(MCAST, 16'h8808, 16'h0001, 16'h0004, 0, 17);
        end_frame(1'b1, 1'b0);
        step();
        check("rstp_pause_on", pause, 1'b1);
        rst = 1'b1; step(); rst = 1'b0;
        check("rstp_pause", pause, 1'b0);
        check("rstp_timer", pause_timer, 16'd0);

        // RxFlow dropping clears an active pause
        send_frame(MCAST, 16'h8808, 16'h0001, 16'h0006, 0, 17);
        end_frame(1'b1, 1'b0);
        step();
        check("flow_pause_on", pause, 1'b1);
        rx_flow = 1'b0;
        step();
        check("flow_timer", pause_timer, 16'd0);
        check("flow_pause", pause, 1'b0);
        rx_flow = 1'b1;
        step();

        // Unicast destination equal to the station address
        pass_all = 1'b1;
        mac = STA;
        send_frame(STA, 16'h8808, 16'h0001, 16'h0007, 0, 17);
        end_frame(1'b1, 1'b0);
        check("uc_rpf", rx_pause_frm, UC_EXP);
        check("uc_timer", pause_timer, UC_EXP ? 16'd7 : 16'd0);
        check("uc_drop", drop_frame, 1'b0);
        send_frame(48'h0011_2233_4466, 16'h8808, 16'h0001, 16'h0008, 0, 17);
        end_frame(1'b1, 1'b0);
        check("uc_other_rpf", rx_pause_frm, 1'b0);
        check("uc_other_timer", pause_timer, UC_EXP ? 16'd7 : 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/eth_rxpausectrl.md
ETH_RXPAUSECTRL -- requirements
Module: eth_rxpausectrl

Interface
REQ-001 Parameter CTRL_TYPE, default 16'h8808, MAC control Type/Length value.
REQ-002 Parameter PAUSE_OPCODE, default 16'h0001, PAUSE opcode value.
REQ-003 MRxClk  in  1  receive clock; all logic SHALL be on its rising edge.
REQ-004 RxReset  in  1  reset, synchronous, active-high.
REQ-005 RxData  in  8  received byte, valid when RxValid=1.
REQ-006 RxValid  in  1  byte strobe.
REQ-007 RxStartFrm  in  1  first byte (destination byte 0) of a frame, qualified by RxValid.
REQ-008 RxEndFrm  in  1  one-cycle end-of-frame pulse, after the last byte.
REQ-009 CrcOk  in  1  CRC result, valid with RxEndFrm.
REQ-010 RxFlow  in  1  honour received PAUSE frames.
REQ-011 PassAll  in  1  pass control frames to the host.
REQ-012 MAC  in  48  station address, MAC[47:40] sent first.
REQ-013 SlotTick  in  1  one-cycle pulse per 512 bit times.
REQ-014 Pause  out  1  transmitter must hold off.
REQ-015 ReceivedPauseFrm  out  1  one-cycle pulse, valid PAUSE accepted.
REQ-016 DropFrame  out  1  one-cycle pulse, current frame must not reach the host.
REQ-017 PauseTimer  out  16  remaining pause quanta.

Function
REQ-018 States IDLE, RECV, DISCARD; RxValid&RxStartFrm SHALL enter RECV from any state, byte count cleared to 1.
REQ-019 In RECV, each RxValid byte SHALL increment a 6-bit byte counter; counter saturates at 63, never wraps.
REQ-020 Bytes 0-5 SHALL be compared with 01-80-C2-00-00-01 (and MAC per REQ-034); mismatch on any byte of both SHALL go to DISCARD.
REQ-021 Bytes 12-13 SHALL set a CtrlType flag when equal to CTRL_TYPE; bytes 14-15 a PauseOp flag when equal to PAUSE_OPCODE; bytes 16-17 SHALL be latched as a 16-bit timer value, high byte first.
REQ-022 Non-control type SHALL go to DISCARD; DISCARD and RECV SHALL return to IDLE on RxEndFrm.
REQ-023 On RxEndFrm in RECV: if address match, CtrlType, PauseOp, CrcOk, byte count >= 18 and RxFlow, ReceivedPauseFrm SHALL pulse and PauseTimer load the latched value on the same edge (latency 1 cycle from RxEndFrm).
REQ-024 DropFrame SHALL pulse 1 cycle after RxEndFrm when CtrlType=1 and PassAll=0, independent of CrcOk/opcode.
REQ-025 PauseTimer SHALL decrement by 1 on SlotTick when nonzero; never underflows.
REQ-026 Load and SlotTick same cycle: load wins, no decrement.
REQ-027 Received value 0 SHALL clear PauseTimer, deasserting Pause next cycle.
REQ-028 Pause SHALL equal (PauseTimer != 0) & RxFlow, registered; RxFlow low clears PauseTimer.
REQ-029 RxEndFrm while IDLE SHALL be ignored; RxStartFrm mid-frame SHALL abandon the frame with no pulses.

Reset
REQ-030 RxReset SHALL force IDLE, byte counter 0, flags 0, PauseTimer 0, Pause 0, ReceivedPauseFrm 0, DropFrame 0.
REQ-031 Reset mid-frame SHALL discard the frame; following bytes ignored until next RxStartFrm.
REQ-032 Reset during pause SHALL clear Pause next cycle.

Configuration
REQ-033 Macro ETH_RXPAUSE_UNICAST_EN selects destination acceptance.
REQ-034 Defined: destination equal to MAC also matches; undefined: only 01-80-C2-00-00-01 matches, MAC unused.

Structure
REQ-035 Package eth_rxpause_pkg SHALL hold the state typedef, reserved multicast address, header offsets (6, 12, 14, 16, 18).
REQ-036 Sub-module eth_pausetimer SHALL implement PauseTimer load/decrement/clear and Pause.

Verification
REQ-037 PAUSE to multicast, timer 16'h0003, CrcOk=1, RxFlow=1 -> ReceivedPauseFrm 1 cycle after RxEndFrm, Pause high for exactly 3 SlotTicks.
REQ-038 Same frame with CrcOk=0 -> no pulse, Pause stays 0; DropFrame pulses if PassAll=0.
REQ-039 Frame type 16'h0800 -> no pulses, state DISCARD until RxEndFrm.
REQ-040 Pausing with timer 5, second PAUSE timer 0 -> Pause falls 1 cycle after the second load.
REQ-041 Load coinciding with SlotTick, value 16'h0002 -> PauseTimer reads 2, then 1, 0 on following ticks.
REQ-042 Destination = MAC 00-11-22-33-44-55 -> accepted with ETH_RXPAUSE_UNICAST_EN, ignored without.
